// File: rtl/mini_intc.sv
// Four-source interrupt controller: edge-detected sticky pending bits, per-source mask,
// fixed priority (source 0 highest), single-cycle ack and sticky overflow flags.
module mini_intc #(
    parameter int NUM_SRC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic       mask_we,
    input  logic [3:0] mask_data,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic       irq_out,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] overflow
);

    logic [3:0] prev_in_r;
    logic [3:0] pending_r;
    logic [3:0] mask_r;
    logic [3:0] overflow_r;
    logic       irq_out_r;
    logic [1:0] irq_id_r;

    logic [3:0] evt_s;
    logic       accept_s;
    logic [3:0] clr_s;
    logic [3:0] ovf_set_s;
    logic [3:0] pending_nxt_s;
    logic [3:0] mask_nxt_s;
    logic [3:0] overflow_nxt_s;
    logic [3:0] active_nxt_s;

    // Lowest set index of v; 0 when v is empty.
    function automatic logic [1:0] prio_id(input logic [3:0] v);
        logic [1:0] id;
        casez (v)
            4'b???1: id = 2'd0;
            4'b??10: id = 2'd1;
            4'b?100: id = 2'd2;
            4'b1000: id = 2'd3;
            default: id = 2'd0;
        endcase
        return id;
    endfunction

    // Next-state for pending, mask and overflow; outputs are registered from this next state
    // so irq_out/irq_id always equal the function of the pending and mask registers.
    always_comb begin
        evt_s          = irq_in & ~prev_in_r;
        accept_s       = ack & irq_out_r;
        clr_s          = 4'b0000;
        if (accept_s) begin
            clr_s = 4'b0001 << irq_id_r;
        end else begin
            clr_s = 4'b0000;
        end
        ovf_set_s      = evt_s & pending_r & ~clr_s;
        pending_nxt_s  = evt_s | (pending_r & ~clr_s);
        if (mask_we) begin
            mask_nxt_s = mask_data;
        end else begin
            mask_nxt_s = mask_r;
        end
        // A new overflow in the same cycle as ovf_clr is kept.
        if (ovf_clr) begin
            overflow_nxt_s = ovf_set_s;
        end else begin
            overflow_nxt_s = overflow_r | ovf_set_s;
        end
        active_nxt_s   = pending_nxt_s & mask_nxt_s;
    end

    // State and output registers; reset discards any event on the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_in_r  <= 4'hF;
            pending_r  <= 4'h0;
            mask_r     <= 4'hF;
            overflow_r <= 4'h0;
            irq_out_r  <= 1'b0;
            irq_id_r   <= 2'd0;
        end else begin
            prev_in_r  <= irq_in;
            pending_r  <= pending_nxt_s;
            mask_r     <= mask_nxt_s;
            overflow_r <= overflow_nxt_s;
            irq_out_r  <= |active_nxt_s;
            irq_id_r   <= prio_id(active_nxt_s);
        end
    end

    assign irq_out  = irq_out_r;
    assign irq_id   = irq_id_r;
    assign pending  = pending_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_mini_intc.sv
// Directed, table-driven bench for mini_intc plus hand-written reset-hold and
// periodic-timer sequences.
module tb_mini_intc;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_data;
    logic       ack;
    logic       ovf_clr;
    logic       irq_out;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overflow;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] irq;
        logic       mwe;
        logic [3:0] mdata;
        logic       ack;
        logic       oclr;
        logic       rst;
        logic [3:0] e_pend;
        logic       e_out;
        logic [1:0] e_id;
        logic [3:0] e_ovf;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    mini_intc #(.NUM_SRC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .mask_we  (mask_we),
        .mask_data(mask_data),
        .ack      (ack),
        .ovf_clr  (ovf_clr),
        .irq_out  (irq_out),
        .irq_id   (irq_id),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] i, input logic mwe, input logic [3:0] md,
                         input logic a, input logic oc, input logic r);
        irq_in    = i;
        mask_we   = mwe;
        mask_data = md;
        ack       = a;
        ovf_clr   = oc;
        rst       = r;
    endtask

    initial begin
        int rises;
        int wc;
        logic prev_out;
        checks   = 0;
        failures = 0;

        //              irq    mwe   mdata  ack   oclr  rst  | pend  out   id     ovf
        vecs[0]  = '{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0}; // reset, lines high
        vecs[1]  = '{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0}; // held high: no event
        vecs[2]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
        vecs[3]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 2'd2, 4'h0}; // single pulse src2
        vecs[4]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0}; // ack
        vecs[5]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 2'd1, 4'h0}; // src3+src1
        vecs[6]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h8, 1'b1, 2'd3, 4'h0};
        vecs[7]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
        vecs[8]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0}; // idle ack ignored
        vecs[9]  = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0}; // src0 pulse
        vecs[10] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0};
        vecs[11] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 4'h1}; // overflow
        vecs[12] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0}; // ovf_clr
        vecs[13] = '{4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0}; // set+ack collide
        vecs[14] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
        vecs[15] = '{4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0}; // mask src0
        vecs[16] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 4'h0};
        vecs[17] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 4'h0}; // ack ignored
        vecs[18] = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0}; // unmask
        vecs[19] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 2'd0, 4'h0};
        vecs[20] = '{4'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 2'd2, 4'h0}; // ack uses old mask
        vecs[21] = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 2'd2, 4'h0};
        vecs[22] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
        vecs[23] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, 4'h0};
        vecs[24] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, 4'h0};
        vecs[25] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 4'h2}; // set beats ovf_clr
        vecs[26] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
        vecs[27] = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 2'd3, 4'h0};
        vecs[28] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 2'd3, 4'h0};
        vecs[29] = '{4'h8, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0}; // mid-op reset
        vecs[30] = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
        vecs[31] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, 4'h0}; // mask back to F

        drive(4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].irq, vecs[i].mwe, vecs[i].mdata, vecs[i].ack, vecs[i].oclr, vecs[i].rst);
            step();
            check($sformatf("v%0d.pending", i),  pending,  vecs[i].e_pend);
            check($sformatf("v%0d.irq_out", i),  irq_out,  vecs[i].e_out);
            check($sformatf("v%0d.irq_id", i),   irq_id,   vecs[i].e_id);
            check($sformatf("v%0d.overflow", i), overflow, vecs[i].e_ovf);
        end

        // Reset with all lines high, release and keep them high for 10 cycles.
        drive(4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        step();
        drive(4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("hold%0d.pending", c),  pending,  0);
            check($sformatf("hold%0d.irq_out", c),  irq_out,  0);
            check($sformatf("hold%0d.overflow", c), overflow, 0);
        end
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();

        // Periodic source, period 10, acked 3 cycles after each irq_out rise.
        rises    = 0;
        wc       = -1;
        prev_out = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive({3'b000, (c % 10) == 0}, 1'b0, 4'h0, (wc == 3), 1'b0, 1'b0);
            if (wc == 3) wc = -1;
            step();
            check($sformatf("timer%0d.overflow", c), overflow, 0);
            if (irq_out && !prev_out) begin
                rises++;
                wc = 0;
                check($sformatf("timer%0d.irq_id", c), irq_id, 0);
            end else if (wc >= 0) begin
                wc++;
            end
            prev_out = irq_out;
        end
        check("timer.rises", rises, 10);
        check("timer.final_out", irq_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
